// File: rtl/lstm_gate_weight_streamer.sv
// Weight RAM for NUM_GATES LSTM gate matrices plus a sequencer that streams a row range over
// valid/ready. Define WEIGHT_PARITY_EN to store an even-parity bit per word and expose parity_err.
module lstm_gate_weight_streamer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned READ_BURST = 2,
    parameter int unsigned NUM_GATES  = 4,
    parameter int unsigned ROWS       = 128,
    parameter int unsigned COLS       = 128,
    localparam int unsigned WPR   = COLS / READ_BURST,
    localparam int unsigned DEPTH = NUM_GATES * ROWS * WPR,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned GW    = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1,
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned WAW   = (ROWS * WPR > 1) ? $clog2(ROWS * WPR) : 1,
    localparam int unsigned DW    = DATA_WIDTH * READ_BURST
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [GW-1:0]  wr_gate,
    input  logic [WAW-1:0] wr_addr,
    input  logic [DW-1:0]  wr_data,
    input  logic           start,
    input  logic [GW-1:0]  req_gate,
    input  logic [RW-1:0]  req_row,
    input  logic [RW:0]    req_nrows,
    output logic           busy,
    output logic           req_err,
    output logic [DW-1:0]  out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last_col,
    output logic           out_last_row,
`ifdef WEIGHT_PARITY_EN
    output logic           parity_err,
`endif
    output logic           done
);
    localparam int unsigned CW = (WPR > 1) ? $clog2(WPR) : 1;
`ifdef WEIGHT_PARITY_EN
    localparam int unsigned MW = DW + 1;
`else
    localparam int unsigned MW = DW;
`endif

    typedef enum logic [1:0] {StIdle, StSetup, StStream, StDrain} state_e;
    state_e state_q, state_d;

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] ram_q;
    logic [MW-1:0] wr_word;
    logic [AW-1:0] wr_ptr;

    logic [GW-1:0] gate_q;
    logic [RW-1:0] row_q;
    logic [RW:0]   nrows_q;
    logic [AW-1:0] ptr_q;
    logic [CW-1:0] col_q;
    logic [RW:0]   rcnt_q;
    logic          pend_q, pend_lc_q, pend_lr_q;
    logic [DW-1:0] buf_data_q [2];
    logic [1:0]    buf_lc_q, buf_lr_q;
    logic          head_q;
    logic [1:0]    cnt_q;
    logic          err_q, done_q;
    logic          req_ok, pop, issue, last_col, last_row, last_word, drained, tail;
`ifdef WEIGHT_PARITY_EN
    logic [1:0]    buf_pe_q;
    logic          rd_pe;
`endif

    always_comb begin
        req_ok    = (req_nrows != '0) && (32'(req_row) + 32'(req_nrows) <= ROWS) &&
                    (32'(req_gate) < NUM_GATES);
        pop       = (cnt_q != 2'd0) && out_ready;
        // Credit: buffered + in-flight words may never exceed the two buffer slots.
        issue     = (state_q == StStream) && (32'(cnt_q) + 32'(pend_q) - 32'(pop) < 32'd2);
        last_col  = (col_q == CW'(WPR - 1));
        last_row  = (rcnt_q == nrows_q - 1'b1);
        last_word = issue && last_col && last_row;
        drained   = pop && (cnt_q == 2'd1) && !pend_q;
        tail      = head_q ^ cnt_q[0];
        wr_ptr    = AW'(32'(wr_gate) * ROWS * WPR + 32'(wr_addr));
`ifdef WEIGHT_PARITY_EN
        wr_word   = {^wr_data, wr_data};
        rd_pe     = ^ram_q;
`else
        wr_word   = wr_data;
`endif
    end

    // Non-blocking read and write in one block: a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
        if (issue) ram_q <= mem[ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start && req_ok) state_d = StSetup;
            StSetup:  state_d = StStream;
            StStream: if (last_word) state_d = StDrain;
            StDrain:  if (drained) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q != StIdle);
        req_err      = err_q;
        done         = done_q;
        out_valid    = (cnt_q != 2'd0);
        out_data     = buf_data_q[head_q];
        out_last_col = out_valid && buf_lc_q[head_q];
        out_last_row = out_valid && buf_lr_q[head_q];
`ifdef WEIGHT_PARITY_EN
        parity_err   = out_valid && buf_pe_q[head_q];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q        <= '0;
            row_q         <= '0;
            nrows_q       <= '0;
            ptr_q         <= '0;
            col_q         <= '0;
            rcnt_q        <= '0;
            pend_q        <= 1'b0;
            pend_lc_q     <= 1'b0;
            pend_lr_q     <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_lc_q      <= '0;
            buf_lr_q      <= '0;
            head_q        <= 1'b0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
`ifdef WEIGHT_PARITY_EN
            buf_pe_q      <= '0;
`endif
        end else begin
            err_q  <= (state_q == StIdle) && start && !req_ok;
            done_q <= (state_q == StDrain) && drained;
            if ((state_q == StIdle) && start && req_ok) begin
                gate_q  <= req_gate;
                row_q   <= req_row;
                nrows_q <= req_nrows;
            end
            if (state_q == StSetup) begin
                ptr_q  <= AW'(32'(gate_q) * ROWS * WPR + 32'(row_q) * WPR);
                col_q  <= '0;
                rcnt_q <= '0;
            end else if (issue) begin
                ptr_q <= ptr_q + 1'b1;
                if (last_col) begin
                    col_q  <= '0;
                    rcnt_q <= rcnt_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            pend_q    <= issue;
            pend_lc_q <= last_col;
            pend_lr_q <= last_row;
            if (pend_q) begin
                buf_data_q[tail] <= ram_q[DW-1:0];
                buf_lc_q[tail]   <= pend_lc_q;
                buf_lr_q[tail]   <= pend_lr_q;
`ifdef WEIGHT_PARITY_EN
                buf_pe_q[tail]   <= rd_pe;
`endif
            end
            head_q <= head_q ^ pop;
            cnt_q  <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end
endmodule

// File: doc/lstm_gate_weight_streamer.md
Name: lstm_gate_weight_streamer

Overview:
Parametrised weight store for all LSTM gates of one direction. NUM_GATES gate matrices live in one block RAM, each ROWS x COLS elements, packed READ_BURST elements per word. An internal sequencer streams a requested range of rows, row-major, to the MAC array over a valid/ready interface, with full backpressure support. A single write port loads weights at runtime.

Parameters:
DATA_WIDTH, 16, bits per weight element (signed)
READ_BURST, 2, elements packed per memory word
NUM_GATES, 4, gate matrices held (i, f, g, o order)
ROWS, 128, rows per gate matrix
COLS, 128, elements per row; must be a multiple of READ_BURST
WPR, COLS/READ_BURST, derived: words per row
DEPTH, NUM_GATES*ROWS*WPR, derived: total words; AW = clog2(DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_gate  in  clog2(NUM_GATES)  gate of write
wr_addr  in  clog2(ROWS*WPR)  word index within gate
wr_data  in  DATA_WIDTH*READ_BURST  packed word; element 0 in LSBs
start  in  1  request pulse; sampled only in IDLE
req_gate  in  clog2(NUM_GATES)  gate to stream
req_row  in  clog2(ROWS)  first row
req_nrows  in  clog2(ROWS)+1  row count
busy  out  1  high outside IDLE
req_err  out  1  one-cycle pulse: request rejected
out_data  out  DATA_WIDTH*READ_BURST  streamed word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when valid & ready
out_last_col  out  1  word is last of its row
out_last_row  out  1  word belongs to last requested row
done  out  1  one-cycle pulse after final word accepted

Behaviour:
- Reset: busy, req_err, out_valid, out_last_col, out_last_row, done = 0; out_data = 0; FSM = IDLE; output buffer emptied. RAM contents not cleared.
- Physical address = gate*ROWS*WPR + row*WPR + col; writes go to wr_gate*ROWS*WPR + wr_addr, 1-cycle synchronous write, accepted in any state.
- FSM IDLE -> SETUP -> STREAM -> DRAIN -> IDLE.
- IDLE: on start, validate; req_nrows==0, req_row+req_nrows>ROWS or req_gate>=NUM_GATES -> req_err pulse next cycle, stay IDLE. Otherwise latch, go SETUP. start outside IDLE ignored, no error.
- SETUP (1 cycle): compute base address into linear read pointer; col/row counters cleared.
- STREAM: issue one RAM read per cycle when credit allows; read latency 1. 2-entry output buffer; issue only if (buffer count + in-flight read - pop this cycle) < 2, so no data is ever dropped. Pointer increments linearly; col counter wraps at WPR-1, incrementing row counter. After last word issued -> DRAIN.
- DRAIN: wait until buffer empty and last word accepted; done pulses the cycle after that handshake; -> IDLE.
- Latency: start sampled at edge N -> first out_valid after edge N+3; with out_ready held high, one word per cycle, nrows*WPR words contiguous.
- out_data/out_last_* stable while out_valid & !out_ready (AXI-stream rule); out_valid never drops without handshake.
- Read-during-write to same address: read returns old data.
- rst_n asserted mid-stream: immediate abort, all outputs to reset values, no done.

Optional Feature:
WEIGHT_PARITY_EN: each RAM word stores an extra even-parity bit computed on write; checked on read; adds output port parity_err (1 bit) asserted with the faulty word while it is valid and cleared on its handshake; stream continues. Without macro: no parity bit, no port, word width exactly DATA_WIDTH*READ_BURST.

Test Plan:
- Write gate 1 words 0..63 with value {idx, ~idx}; start gate=1,row=0,nrows=1 -> 64 words in order, first out_valid at N+3, out_last_col on word 63, out_last_row all, done once.
- nrows=3 from row 125, out_ready random 50% -> 192 words, no loss/duplication, data held during stalls, out_last_col every 64th.
- req_row=127,nrows=2 and nrows=0 -> req_err pulse each, busy stays 0, no out_valid.
- Write address being streamed during STREAM -> old data returned on same-cycle read, new data on later pass.
- rst_n low at word 20 of a stream -> outputs zero asynchronously; new request after release streams from word 0 correctly.
- WEIGHT_PARITY_EN: flip stored parity bit of word 5 via backdoor -> parity_err high only with word 5.
